// File: rtl/std_flow_buffer.sv
// Depth-entry circular stream buffer with registered output, occupancy/almost-full reporting,
// selectable ready timing and a synchronous flush.
module std_flow_buffer #(
    parameter type         T               = logic,
    parameter int unsigned Depth           = 4,
    parameter bit          ReadyMode       = 1'b0,
    parameter int unsigned AlmostFullLevel = (Depth > 1) ? Depth - 1 : 1,
    localparam int unsigned Cw             = $clog2(Depth + 1),
    localparam int unsigned Pw             = (Depth > 1) ? $clog2(Depth) : 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          flush_i,
    input  logic          stream_in_valid_i,
    output logic          stream_in_ready_o,
    input  T              stream_in_payload_i,
    output logic          stream_out_valid_o,
    input  logic          stream_out_ready_i,
    output T              stream_out_payload_o,
    output logic [Cw-1:0] occupancy_o,
    output logic          almost_full_o
);

    if (Depth < 1) begin : gen_depth_check
        $error("std_flow_buffer: Depth must be >= 1");
    end
    if (AlmostFullLevel < 1 || AlmostFullLevel > Depth) begin : gen_af_check
        $error("std_flow_buffer: AlmostFullLevel must be in 1..Depth");
    end

    localparam logic [Cw-1:0] DepthC  = Cw'(Depth);
    localparam logic [Cw-1:0] AfLevel = Cw'(AlmostFullLevel);
    localparam logic [Pw-1:0] PtrMax  = Pw'(Depth - 1);

    T              mem_q [Depth];
    logic [Pw-1:0] wr_ptr_q, wr_ptr_d;
    logic [Pw-1:0] rd_ptr_q, rd_ptr_d;
    logic [Cw-1:0] count_q, count_d;
    logic          full;
    logic          push;
    logic          pop;

    function automatic logic [Pw-1:0] ptr_inc(input logic [Pw-1:0] p);
        return (p == PtrMax) ? '0 : p + Pw'(1);
    endfunction

    assign full = (count_q == DepthC);

    // Mode 1 lets a full buffer accept when the sink frees a slot in the same cycle.
    assign stream_in_ready_o    = rst_ni && (!full || (ReadyMode && stream_out_ready_i));
    assign stream_out_valid_o   = (count_q != '0);
    assign stream_out_payload_o = mem_q[rd_ptr_q];
    assign occupancy_o          = count_q;
    assign almost_full_o        = (count_q >= AfLevel);

    assign push = stream_in_valid_i && stream_in_ready_o;
    assign pop  = stream_out_valid_o && stream_out_ready_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + Cw'(1);
            2'b01:   count_d = count_q - Cw'(1);
            default: count_d = count_q;
        endcase
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; a full push+pop writes the slot whose old value is being read out.
    always_ff @(posedge clk_i) begin
        if (push && !flush_i) begin
            mem_q[wr_ptr_q] <= stream_in_payload_i;
        end
    end

endmodule

// File: tb/tb_std_flow_buffer.sv
// Scoreboard bench for std_flow_buffer: three instances (4/mode0, 4/mode1, 3/mode0) share a
// clock and reset; directed stimulus queues expected beats, per-instance monitors check output.
module tb_std_flow_buffer;

    logic clk;
    logic rst_n;

    logic       a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_af;
    logic [7:0] a_in_payload, a_out_payload;
    logic [2:0] a_occ;

    logic       b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_af;
    logic [7:0] b_in_payload, b_out_payload;
    logic [2:0] b_occ;

    logic       c_flush, c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_af;
    logic [7:0] c_in_payload, c_out_payload;
    logic [1:0] c_occ;

    logic [7:0] exp_a[$];
    logic [7:0] exp_b[$];
    logic [7:0] exp_c[$];

    int vectors     = 0;
    int miscompares = 0;

    std_flow_buffer #(.T(logic [7:0]), .Depth(4), .ReadyMode(1'b0)) u_a (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(a_flush),
        .stream_in_valid_i(a_in_valid), .stream_in_ready_o(a_in_ready),
        .stream_in_payload_i(a_in_payload), .stream_out_valid_o(a_out_valid),
        .stream_out_ready_i(a_out_ready), .stream_out_payload_o(a_out_payload),
        .occupancy_o(a_occ), .almost_full_o(a_af)
    );

    std_flow_buffer #(.T(logic [7:0]), .Depth(4), .ReadyMode(1'b1)) u_b (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(b_flush),
        .stream_in_valid_i(b_in_valid), .stream_in_ready_o(b_in_ready),
        .stream_in_payload_i(b_in_payload), .stream_out_valid_o(b_out_valid),
        .stream_out_ready_i(b_out_ready), .stream_out_payload_o(b_out_payload),
        .occupancy_o(b_occ), .almost_full_o(b_af)
    );

    std_flow_buffer #(.T(logic [7:0]), .Depth(3), .ReadyMode(1'b0)) u_c (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(c_flush),
        .stream_in_valid_i(c_in_valid), .stream_in_ready_o(c_in_ready),
        .stream_in_payload_i(c_in_payload), .stream_out_valid_o(c_out_valid),
        .stream_out_ready_i(c_out_ready), .stream_out_payload_o(c_out_payload),
        .occupancy_o(c_occ), .almost_full_o(c_af)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void chk(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endfunction

    function automatic void unexpected(input string name, input int act);
        vectors++;
        miscompares++;
        $display("FAIL %s: unexpected beat 0x%0h, expected none", name, act);
    endfunction

    // Monitors: every handshake on an output pops the next expected beat.
    always @(negedge clk) begin
        if (a_out_valid && a_out_ready) begin
            if (exp_a.size() == 0) unexpected("a_beat", int'(a_out_payload));
            else chk("a_beat", int'(a_out_payload), int'(exp_a.pop_front()));
        end
        if (b_out_valid && b_out_ready) begin
            if (exp_b.size() == 0) unexpected("b_beat", int'(b_out_payload));
            else chk("b_beat", int'(b_out_payload), int'(exp_b.pop_front()));
        end
        if (c_out_valid && c_out_ready) begin
            if (exp_c.size() == 0) unexpected("c_beat", int'(c_out_payload));
            else chk("c_beat", int'(c_out_payload), int'(exp_c.pop_front()));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        int  idx;
        int  k;
        bit  acc;
        rst_n = 1'b0;
        {a_flush, a_in_valid, a_out_ready, a_in_payload} = '0;
        {b_flush, b_in_valid, b_out_ready, b_in_payload} = '0;
        {c_flush, c_in_valid, c_out_ready, c_in_payload} = '0;

        // Reset state
        tick();
        tick();
        smp();
        chk("rst_a_ready", int'(a_in_ready), 0);
        chk("rst_a_valid", int'(a_out_valid), 0);
        chk("rst_a_occ", int'(a_occ), 0);
        chk("rst_a_af", int'(a_af), 0);
        chk("rst_b_ready", int'(b_in_ready), 0);
        chk("rst_c_ready", int'(c_in_ready), 0);
        tick();
        rst_n = 1'b1;
        smp();
        chk("rel_a_ready", int'(a_in_ready), 1);

        // Mode 1: full buffer accepts while the sink pops
        tick();
        for (int i = 0; i < 4; i++) begin
            b_in_valid   = 1'b1;
            b_in_payload = 8'(8'hB1 + i);
            exp_b.push_back(8'(8'hB1 + i));
            smp();
            chk("t2_fill_ready", int'(b_in_ready), 1);
            tick();
        end
        b_in_valid = 1'b0;
        smp();
        chk("t2_full_occ", int'(b_occ), 4);
        chk("t2_full_ready", int'(b_in_ready), 0);
        chk("t2_full_af", int'(b_af), 1);
        tick();
        b_in_valid   = 1'b1;
        b_in_payload = 8'h0A;
        b_out_ready  = 1'b1;
        exp_b.push_back(8'h0A);
        smp();
        chk("t2_comb_ready", int'(b_in_ready), 1);
        chk("t2_occ_before", int'(b_occ), 4);
        tick();
        b_in_valid = 1'b0;
        smp();
        chk("t2_occ_after", int'(b_occ), 4);
        for (k = 0; k < 20 && exp_b.size() != 0; k++) tick();
        chk("t2_drained", exp_b.size(), 0);
        smp();
        chk("t2_end_occ", int'(b_occ), 0);
        tick();

        // Depth 3, toggling sink, pointers wrap
        for (int i = 0; i < 20; i++) exp_c.push_back(8'(i));
        idx = 0;
        for (int cyc = 0; cyc < 300 && exp_c.size() != 0; cyc++) begin
            c_in_valid   = (idx < 20);
            c_in_payload = 8'(idx);
            c_out_ready  = (cyc % 2 == 0);
            smp();
            acc = c_in_valid && c_in_ready;
            tick();
            if (acc) idx++;
        end
        c_in_valid  = 1'b0;
        c_out_ready = 1'b0;
        chk("t3_drained", exp_c.size(), 0);
        chk("t3_accepted", idx, 20);
        smp();
        chk("t3_end_occ", int'(c_occ), 0);
        tick();

        // Mode 0: fill, almost-full, back-pressure, then drain
        a_out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            a_in_valid   = 1'b1;
            a_in_payload = 8'(i);
            exp_a.push_back(8'(i));
            smp();
            chk("t1_occ", int'(a_occ), i - 1);
            chk("t1_af", int'(a_af), (i - 1 >= 3) ? 1 : 0);
            chk("t1_ready", int'(a_in_ready), 1);
            tick();
        end
        a_in_payload = 8'h05;
        exp_a.push_back(8'h05);
        repeat (2) begin
            smp();
            chk("t1_full_ready", int'(a_in_ready), 0);
            chk("t1_full_occ", int'(a_occ), 4);
            chk("t1_full_af", int'(a_af), 1);
            tick();
        end
        a_out_ready = 1'b1;
        smp();
        chk("t1_no_comb_ready", int'(a_in_ready), 0);
        tick();
        smp();
        chk("t1_ready_back", int'(a_in_ready), 1);
        chk("t1_occ_3", int'(a_occ), 3);
        tick();
        a_in_valid = 1'b0;
        for (k = 0; k < 20 && exp_a.size() != 0; k++) tick();
        chk("t1_drained", exp_a.size(), 0);
        smp();
        chk("t1_end_occ", int'(a_occ), 0);
        tick();

        // One-cycle latency, no bypass
        a_in_valid   = 1'b1;
        a_in_payload = 8'h55;
        exp_a.push_back(8'h55);
        smp();
        chk("t4_valid_cycle_n", int'(a_out_valid), 0);
        tick();
        a_in_valid = 1'b0;
        smp();
        chk("t4_valid_n1", int'(a_out_valid), 1);
        chk("t4_payload_n1", int'(a_out_payload), 8'h55);
        chk("t4_occ_n1", int'(a_occ), 1);
        tick();
        smp();
        chk("t4_occ_end", int'(a_occ), 0);
        tick();

        // Flush with simultaneous push and pop
        a_out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a_in_valid   = 1'b1;
            a_in_payload = 8'(8'h31 + i);
            exp_a.push_back(8'(8'h31 + i));
            tick();
        end
        a_flush      = 1'b1;
        a_in_payload = 8'h77;
        a_out_ready  = 1'b1;
        smp();
        chk("t5_occ_before", int'(a_occ), 3);
        chk("t5_ready_flush", int'(a_in_ready), 1);
        tick();
        a_flush    = 1'b0;
        a_in_valid = 1'b0;
        exp_a.delete();
        smp();
        chk("t5_occ_after", int'(a_occ), 0);
        chk("t5_valid_after", int'(a_out_valid), 0);
        repeat (4) tick();
        smp();
        chk("t5_occ_later", int'(a_occ), 0);
        tick();

        // Reset mid-stream drops contents
        a_out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            a_in_valid   = 1'b1;
            a_in_payload = 8'(8'h61 + i);
            exp_a.push_back(8'(8'h61 + i));
            tick();
        end
        a_in_valid = 1'b0;
        rst_n      = 1'b0;
        smp();
        chk("t6_occ_before", int'(a_occ), 2);
        chk("t6_ready_in_rst", int'(a_in_ready), 0);
        tick();
        exp_a.delete();
        smp();
        chk("t6_rst_ready", int'(a_in_ready), 0);
        chk("t6_rst_valid", int'(a_out_valid), 0);
        chk("t6_rst_occ", int'(a_occ), 0);
        chk("t6_rst_af", int'(a_af), 0);
        tick();
        rst_n = 1'b1;
        smp();
        chk("t6_rel_ready", int'(a_in_ready), 1);
        chk("t6_rel_valid", int'(a_out_valid), 0);
        tick();
        a_in_valid   = 1'b1;
        a_in_payload = 8'h66;
        a_out_ready  = 1'b1;
        exp_a.push_back(8'h66);
        tick();
        a_in_valid = 1'b0;
        for (k = 0; k < 20 && exp_a.size() != 0; k++) tick();
        chk("t6_drained", exp_a.size(), 0);
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/std_flow_buffer.md
Name: std_flow_buffer

Overview:
- Parametrised successor to the two-entry flow stage: a DEPTH-entry circular stream buffer with selectable ready timing, occupancy reporting, an almost-full flag and a synchronous flush.
- Sits between std_stream_intf producers and consumers to absorb bursts and to break valid and ready timing paths in pipelines.
- Output is always registered, with a fixed latency of 1 cycle.

Parameters:
- T, logic: payload type. $bits(T) must equal the payload width of both interfaces (static assert).
- DEPTH, 4: number of storage entries. Must be >=1; non-power-of-2 values are supported.
- READY_MODE, 0: 0 = ready is driven only from registered state; 1 = ready may also rise combinationally from stream_out.ready when the buffer is full.
- ALMOST_FULL_LEVEL, DEPTH-1: occupancy at or above which almost_full asserts. Range 1..DEPTH (static assert).
- Derived: CW = $clog2(DEPTH+1).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, synchronous and active-low (rst==0 resets).
- flush  in  1  synchronous clear of all buffered beats.
- stream_in  std_stream_intf.in  valid/ready + $bits(T)  input stream.
- stream_out  std_stream_intf.out  valid/ready + $bits(T)  output stream.
- occupancy  out  CW  number of valid entries, taken from the count register.
- almost_full  out  1  occupancy >= ALMOST_FULL_LEVEL.

Behaviour:
- State: payload array [DEPTH]; wr_ptr and rd_ptr, each $clog2(DEPTH) bits (1 bit if DEPTH==1); count, CW bits.
- Handshake definitions:
  - push = stream_in.valid && stream_in.ready.
  - pop = stream_out.valid && stream_out.ready.
- Outputs:
  - stream_out.valid = (count != 0).
  - stream_out.payload = mem[rd_ptr].
- Ready:
  - READY_MODE 0: stream_in.ready = (count < DEPTH). There is no combinational path from stream_out.ready.
  - READY_MODE 1: stream_in.ready = (count < DEPTH) || stream_out.ready.
  - Both modes: stream_in.ready is forced 0 while rst==0.
- Latency: a beat pushed in cycle N is presented on stream_out no earlier than cycle N+1. There is no same-cycle bypass, even when the buffer is empty.
- Ordering: strict FIFO. No beat is lost or duplicated except by flush.
- Pointer update:
  - On push: mem[wr_ptr] <= payload, then wr_ptr advances.
  - On pop: rd_ptr advances.
  - Wrap: a pointer at DEPTH-1 goes to 0, with explicit compare rather than natural overflow.
- Count update:
  - Push only: +1.
  - Pop only: -1.
  - Push and pop together: unchanged.
  - Neither: unchanged.
- Full with push and pop together: possible only in READY_MODE 1. Count stays DEPTH and the write targets the slot being freed (wr_ptr==rd_ptr). This is legal because the read is of the old value.
- Empty with valid input: the pop is impossible, so the cycle is a push only.
- Output stability: stream_out.payload and stream_out.valid are held stable while valid && !ready.
- Flush (registered):
  - On the next edge, count, wr_ptr and rd_ptr go to 0.
  - A pop in the flush cycle completes normally.
  - A push in the flush cycle is discarded.
  - Ready follows its normal equation during flush.
- Reset (rst==0 at posedge): count, wr_ptr and rd_ptr go to 0.
  - Held resets: stream_out.valid=0, occupancy=0, almost_full=0, stream_in.ready=0.
  - Reset arriving mid-burst drops all contents; reset takes priority over flush.
- Payload array: not reset. Contents are don't-care while the entry is invalid.
- almost_full: decoded from the count register, so it is glitch-free relative to the handshakes.
- DEPTH==1: behaves as a half-rate register.
  - READY_MODE 0 gives back-to-back throughput of 1 beat per 2 cycles.
  - READY_MODE 1 gives 1 beat per cycle when the sink is always ready.

Test Plan:
1. DEPTH=4, READY_MODE=0; push 0x1,0x2,0x3,0x4 with stream_out.ready=0 -> occupancy 1,2,3,4; almost_full asserts at occupancy 3; ready=0 at occupancy 4; a 5th beat 0x5 held valid is not accepted. Then set ready=1 -> output 0x1..0x4 on consecutive cycles, then 0x5.
2. DEPTH=4, READY_MODE=1, buffer full, stream_out.ready=1 and stream_in.valid=1 with 0xA -> stream_in.ready=1; occupancy stays 4; after 4 further pops 0xA emerges last.
3. DEPTH=3 (non-power-of-2); 20 beats 0..19, source always valid, sink ready toggling 1010... -> output exactly 0..19 in order; pointers wrap 2->0 with no loss.
4. Empty buffer; push 0x55 in cycle N -> stream_out.valid=0 in cycle N and =1 with 0x55 in cycle N+1; occupancy=1 in cycle N+1.
5. Occupancy 3; in one cycle assert flush, push 0x77 and pop -> the popped beat is delivered; next cycle occupancy=0 and valid=0; 0x77 never appears.
6. Occupancy 2, drive rst=0 for 1 cycle -> during reset ready=0, valid=0 and occupancy=0; after release, ready=1; the next pushed beat is the first out.
